// File: rtl/parity_check8_pkg.sv
// Shared definitions for the 8-bit parity macros.
//
// Contents:
//   PAR_EVEN / PAR_ODD : parity-sense constants
//   parity_err8()      : 8-bit parity check with selectable sense. It returns 1
//                        when data, parity bit and sense together have odd
//                        weight, which means the word is in error. The
//                        generator-side wrappers reuse the same function.
package parity_check8_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic parity_err8(input logic [7:0] d,
                                         input logic       p,
                                         input logic       sense);
        return (^d) ^ p ^ sense;
    endfunction

endpackage

// File: rtl/parity_check8_tree.sv
// parity_tree8: combinational 8-input XOR reduction with parity bit and sense.
//
// Ports:
//   d     in  8  data byte
//   p     in  1  received parity bit
//   sense in  1  PAR_EVEN or PAR_ODD
//   err   out 1  1 when the byte and parity bit disagree with the sense
module parity_tree8
    import parity_check8_pkg::*;
(
    input  logic [7:0] d,
    input  logic       p,
    input  logic       sense,
    output logic       err
);

    assign err = parity_err8(d, p, sense);

endmodule

// File: rtl/parity_check8.sv
// parity_check8: registered receive-side 8-bit parity checker.
//
// A byte and its transmitted parity bit are captured in stage 1, then checked
// in stage 2. The bench-facing outputs are all registered, so there is no
// combinational path from inputs to outputs. Latency is 2 cycles and a new
// word can be accepted every cycle.
//
// Parameters:
//   ODD   : parity sense, 0 = even, 1 = odd
//   CNT_W : width of the saturating error counter
//
// Ports:
//   CK   in  1      clock, rising edge
//   CD   in  1      synchronous active-high reset
//   VLD  in  1      input word valid
//   D    in  8      received data byte
//   P    in  1      received parity bit
//   CLR  in  1      synchronous clear of STKY and ECNT (the pipeline keeps running)
//   OVLD out 1      output word valid
//   Q    out 8      delayed data byte, holds while OVLD=0
//   PERR out 1      parity error for the word on Q, 0 when OVLD=0
//   STKY out 1      sticky error flag
//   ECNT out CNT_W  saturating count of errored words
module parity_check8
    import parity_check8_pkg::*;
#(
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             VLD,
    input  logic [7:0]       D,
    input  logic             P,
    input  logic             CLR,
    output logic             OVLD,
    output logic [7:0]       Q,
    output logic             PERR,
    output logic             STKY,
    output logic [CNT_W-1:0] ECNT
);

    localparam logic             SENSE    = (ODD != 0) ? PAR_ODD : PAR_EVEN;
    localparam logic [CNT_W-1:0] ECNT_MAX = '1;
    localparam logic [CNT_W-1:0] ECNT_ONE = CNT_W'(1);

    logic             v1_q,   v1_d;
    logic [7:0]       d1_q,   d1_d;
    logic             p1_q,   p1_d;
    logic             ovld_q, ovld_d;
    logic [7:0]       q_q,    q_d;
    logic             perr_q, perr_d;
    logic             stky_q, stky_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic             tree_err;
    logic             err;
    logic [CNT_W-1:0] ecnt_base;

    // The check sits between the capture and check registers.
    parity_tree8 u_tree (
        .d     (d1_q),
        .p     (p1_q),
        .sense (SENSE),
        .err   (tree_err)
    );

    always_comb begin
        // Stage 1: capture. Data holds when no word arrives.
        v1_d = VLD;
        d1_d = VLD ? D : d1_q;
        p1_d = VLD ? P : p1_q;

        // Stage 2: check.
        err    = v1_q & tree_err;
        ovld_d = v1_q;
        q_d    = v1_q ? d1_q : q_q;
        perr_d = err;

        // Clear acts before the new error, so CLR together with an error
        // leaves STKY=1 and ECNT=1.
        stky_d    = (stky_q & ~CLR) | err;
        ecnt_base = CLR ? '0 : ecnt_q;
        ecnt_d    = ecnt_base;
        if (err && (ecnt_base != ECNT_MAX)) begin
            ecnt_d = ecnt_base + ECNT_ONE;
        end
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            v1_q   <= 1'b0;
            d1_q   <= 8'h00;
            p1_q   <= 1'b0;
            ovld_q <= 1'b0;
            q_q    <= 8'h00;
            perr_q <= 1'b0;
            stky_q <= 1'b0;
            ecnt_q <= '0;
        end else begin
            v1_q   <= v1_d;
            d1_q   <= d1_d;
            p1_q   <= p1_d;
            ovld_q <= ovld_d;
            q_q    <= q_d;
            perr_q <= perr_d;
            stky_q <= stky_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign OVLD = ovld_q;
    assign Q    = q_q;
    assign PERR = perr_q;
    assign STKY = stky_q;
    assign ECNT = ecnt_q;

endmodule
